klotski_order_check: RTL and testbench

Consumes the 64-bit board order produced by the colour-sort stage, one tile ID per board position. It serially scans the 16 positions, inverts the map into position-per-tile, and finds the blank. It also checks that the order is a true permutation of 0..15 and counts inversions to decide 15-puzzle solvability. Its results feed the solver/move-planner and the "unsolvable scan" indication on the display path.

---
 rtl/klotski_order_check.sv | 140 ++++++++++++++
 tb/tb_klotski_order_check.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/klotski_order_check.sv
// Serially scans a 4x4 board order, checks that it is a permutation and counts inversions.
// Results: position per tile, blank position, inversion count and 15-puzzle solvability.
module klotski_order_check (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_order,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid_perm,
    output logic        o_solvable,
    output logic [3:0]  o_blank_pos,
    output logic [6:0]  o_inv_count,
    output logic [63:0] o_position
);

    typedef enum logic [1:0] {StIdle, StScan, StEval, StDone} state_e;

    state_e      state_q;
    logic [63:0] shreg_q;
    logic [3:0]  cnt_q;
    logic [15:0] seen_q;
    logic [6:0]  inv_q;
    logic        dup_q;
    logic [63:0] map_q;
    logic [3:0]  blank_q;

    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic        solv_q;
    logic [3:0]  blank_out_q;
    logic [6:0]  inv_out_q;
    logic [63:0] pos_out_q;

    logic [3:0]  tile;
    logic [15:0] greater_mask;
    logic [15:0] greater_seen;
    logic [3:0]  gt_cnt;
    logic [5:0]  map_lsb;
    logic        eval_valid;

    // Tiles above t occupy bits t+1..15; bit 0 (the blank) can never fall in that range.
    always_comb begin
        tile         = shreg_q[63:60];
        greater_mask = 16'hFFFE << tile;
        greater_seen = seen_q & greater_mask;
        gt_cnt       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            gt_cnt = gt_cnt + {3'b000, greater_seen[i]};
        end
        // Tile t sits at nibble 15-t of the map, i.e. LSB index 4*(~t).
        map_lsb    = {~tile, 2'b00};
        eval_valid = ~dup_q & (&seen_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            seen_q      <= '0;
            inv_q       <= '0;
            dup_q       <= 1'b0;
            map_q       <= '0;
            blank_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            solv_q      <= 1'b0;
            blank_out_q <= '0;
            inv_out_q   <= '0;
            pos_out_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        shreg_q     <= i_order;
                        cnt_q       <= '0;
                        seen_q      <= '0;
                        inv_q       <= '0;
                        dup_q       <= 1'b0;
                        map_q       <= '0;
                        blank_q     <= '0;
                        busy_q      <= 1'b1;
                        valid_q     <= 1'b0;
                        solv_q      <= 1'b0;
                        blank_out_q <= '0;
                        inv_out_q   <= '0;
                        pos_out_q   <= '0;
                        state_q     <= StScan;
                    end
                end
                StScan: begin
                    if (seen_q[tile]) begin
                        dup_q <= 1'b1;
                    end else begin
                        seen_q[tile]         <= 1'b1;
                        map_q[map_lsb +: 4]  <= cnt_q;
                        if (tile == 4'd0) begin
                            blank_q <= cnt_q;
                        end
                    end
                    if (tile != 4'd0) begin
                        inv_q <= inv_q + {3'b000, gt_cnt};
                    end
                    shreg_q <= {shreg_q[59:0], 4'h0};
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    valid_q     <= eval_valid;
                    solv_q      <= eval_valid & (inv_q[0] ^ blank_q[2]);
                    blank_out_q <= blank_q;
                    inv_out_q   <= inv_q;
                    pos_out_q   <= map_q;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_valid_perm = valid_q;
    assign o_solvable   = solv_q;
    assign o_blank_pos  = blank_out_q;
    assign o_inv_count  = inv_out_q;
    assign o_position   = pos_out_q;

endmodule

// File: tb/tb_klotski_order_check.sv
// Randomized and directed bench for klotski_order_check against a behavioural board model.
module tb_klotski_order_check;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [63:0] i_order;
    logic        o_busy;
    logic        o_done;
    logic        o_valid_perm;
    logic        o_solvable;
    logic [3:0]  o_blank_pos;
    logic [6:0]  o_inv_count;
    logic [63:0] o_position;

    int n_checks = 0;
    int n_fail   = 0;

    klotski_order_check dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_order      (i_order),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_valid_perm (o_valid_perm),
        .o_solvable   (o_solvable),
        .o_blank_pos  (o_blank_pos),
        .o_inv_count  (o_inv_count),
        .o_position   (o_position)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Works from the board as a list of tiles: first occurrences, counts and pairwise order.
    task automatic model(input logic [63:0] ord, output logic valid, output logic solv,
                         output logic [3:0] blank, output logic [6:0] inv,
                         output logic [63:0] pos);
        int t[16];
        int cnt[16];
        int first[16];
        int n_inv;
        bit ok;
        for (int p = 0; p < 16; p++) begin
            t[p]     = int'(ord[(15 - p) * 4 +: 4]);
            cnt[p]   = 0;
            first[p] = -1;
        end
        for (int p = 0; p < 16; p++) begin
            cnt[t[p]]++;
            if (first[t[p]] < 0) first[t[p]] = p;
        end
        n_inv = 0;
        for (int p = 0; p < 16; p++) begin
            if (t[p] != 0) begin
                for (int u = t[p] + 1; u < 16; u++) begin
                    bit earlier = 1'b0;
                    for (int q = 0; q < p; q++) if (t[q] == u) earlier = 1'b1;
                    if (earlier) n_inv++;
                end
            end
        end
        ok = 1'b1;
        for (int u = 0; u < 16; u++) if (cnt[u] != 1) ok = 1'b0;
        pos = '0;
        for (int u = 0; u < 16; u++) begin
            pos[(15 - u) * 4 +: 4] = (first[u] < 0) ? 4'd0 : 4'(first[u]);
        end
        blank = (first[0] < 0) ? 4'd0 : 4'(first[0]);
        inv   = 7'(n_inv);
        valid = ok;
        solv  = ok && (((n_inv + first[0] / 4) % 2) == 1);
    endtask

    // One transaction: acceptance edge, then o_done expected in the 18th cycle from the start.
    task automatic run_board(input logic [63:0] ord, input bit glitch, input bit start_in_done);
        logic        e_valid, e_solv;
        logic [3:0]  e_blank;
        logic [6:0]  e_inv;
        logic [63:0] e_pos;
        int          busy_cnt;
        int          done_at;
        model(ord, e_valid, e_solv, e_blank, e_inv, e_pos);
        @(negedge i_clk);
        i_start = 1'b1;
        i_order = ord;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_order = {$urandom, $urandom};
        chk("busy_on_accept", 64'(o_busy), 64'd1);
        chk("valid_cleared", 64'({o_valid_perm, o_solvable}), 64'd0);
        busy_cnt = 1;
        done_at  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk);
            #1;
            if (glitch && k == 5) i_start = 1'b1;
            if (glitch && k == 6) i_start = 1'b0;
            if (o_done) begin
                done_at = k;
                break;
            end
            if (o_busy) busy_cnt++;
        end
        i_start = 1'b0;
        if (done_at < 0) begin
            chk("done_timeout", 64'd0, 64'd1);
            return;
        end
        chk("done_latency", 64'(done_at), 64'd17);
        chk("busy_cycles", 64'(busy_cnt), 64'd17);
        chk("busy_at_done", 64'(o_busy), 64'd0);
        chk("valid_perm", 64'(o_valid_perm), 64'(e_valid));
        chk("solvable", 64'(o_solvable), 64'(e_solv));
        chk("blank_pos", 64'(o_blank_pos), 64'(e_blank));
        chk("inv_count", 64'(o_inv_count), 64'(e_inv));
        chk("position", o_position, e_pos);
        if (start_in_done) i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        chk("done_one_cycle", 64'({o_done, o_busy}), 64'd0);
        chk("result_hold", {o_position[55:0], o_inv_count, o_valid_perm},
            {e_pos[55:0], e_inv, e_valid});
    endtask

    task automatic shuffled(output logic [63:0] ord);
        int a[16];
        for (int i = 0; i < 16; i++) a[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int tmp = a[i];
            a[i] = a[j];
            a[j] = tmp;
        end
        for (int i = 0; i < 16; i++) ord[(15 - i) * 4 +: 4] = 4'(a[i]);
    endtask

    initial begin
        logic [63:0] ord;
        int          dones;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_order = '0;
        #13;
        chk("reset_ctrl", 64'({o_busy, o_done, o_valid_perm, o_solvable}), 64'd0);
        chk("reset_data", {o_position[55:0], o_inv_count, o_blank_pos}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_board(64'h123456789ABCDEF0, 1'b0, 1'b0);
        run_board(64'h123456789ABCDFE0, 1'b0, 1'b0);
        run_board(64'h0123456789ABCDEF, 1'b0, 1'b0);
        run_board(64'hFEDCBA9876543210, 1'b0, 1'b0);
        run_board(64'h0, 1'b0, 1'b0);
        run_board(64'h123456789ABCDEF0, 1'b1, 1'b1);

        // Reset mid-scan: outputs clear immediately and the aborted scan never completes.
        @(negedge i_clk);
        i_start = 1'b1;
        i_order = 64'h123456789ABCDEF0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (8) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("midreset_ctrl", 64'({o_busy, o_done, o_valid_perm, o_solvable}), 64'd0);
        chk("midreset_data", o_position | 64'(o_inv_count) | 64'(o_blank_pos), 64'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) dones++;
        end
        chk("no_done_after_reset", 64'(dones), 64'd0);
        run_board(64'h123456789ABCDEF0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            if (n % 3 == 2) ord = {$urandom, $urandom};
            else            shuffled(ord);
            run_board(ord, n % 5 == 0, n % 4 == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
